bridge_arbiter: RTL

- Two-master arbiter in front of the system Bridge.
- M0 is the CPU data port; M1 is a secondary master (DMA/debug loader).
- Serialises their single-word accesses onto the Bridge's processor-side port (address, byte enables, write data, read data).
- Flags accesses that the Bridge would silently drop.

---
 rtl/bridge_arbiter_pkg.sv | 24 ++
 rtl/bridge_arbiter_addr_classifier.sv | 26 ++
 rtl/bridge_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bridge_arbiter_pkg.sv
// Shared constants and types for the bridge arbiter and its address classifier.
// The region bounds must match the constants the Bridge itself decodes with.
package bridge_arbiter_pkg;

    localparam logic [31:0] MIN_DM  = 32'h0000_0000;
    localparam logic [31:0] MAX_DM  = 32'h0000_2FFF;
    localparam logic [31:0] MIN_TC0 = 32'h0000_7F00;
    localparam logic [31:0] MAX_TC0 = 32'h0000_7F0B;
    localparam logic [31:0] MIN_TC1 = 32'h0000_7F10;
    localparam logic [31:0] MAX_TC1 = 32'h0000_7F1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_e;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/bridge_arbiter_addr_classifier.sv
// Combinational decode of a processor-side access into Bridge regions.
// Flags unmapped addresses and partial-word accesses to the timers.
module bridge_arbiter_addr_classifier
    import bridge_arbiter_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [3:0]  byteen_i,
    output logic        hit_dm_o,
    output logic        hit_tc0_o,
    output logic        hit_tc1_o,
    output logic        err_o
);

    logic size_ok;
    logic hit_tc;

    assign hit_dm_o  = in_range(addr_i, MIN_DM, MAX_DM);
    assign hit_tc0_o = in_range(addr_i, MIN_TC0, MAX_TC0);
    assign hit_tc1_o = in_range(addr_i, MIN_TC1, MAX_TC1);
    assign hit_tc    = hit_tc0_o || hit_tc1_o;

    // Timer registers only accept full-word writes (or reads).
    assign size_ok = (byteen_i == 4'b0000) || (byteen_i == 4'b1111);
    assign err_o   = !(hit_dm_o || hit_tc) || (hit_tc && !size_ok);

endmodule

// File: rtl/bridge_arbiter.sv
// Two-master arbiter serialising single-word accesses onto the Bridge port.
// Each transaction walks IDLE -> ACC -> RSP; all outputs come from flops.
module bridge_arbiter
    import bridge_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [DW-1:0] m0_addr,
    input  logic [3:0]    m0_byteen,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic [DW-1:0] m1_addr,
    input  logic [3:0]    m1_byteen,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] br_addr,
    output logic [3:0]    br_byteen,
    output logic [DW-1:0] br_wdata,
    input  logic [DW-1:0] br_rdata,
    output logic          busy,
    output logic          grant_id
);

    state_e        state_q, state_d;
    logic          req_any, sel;
    logic [DW-1:0] sel_addr, sel_wdata;
    logic [3:0]    sel_byteen;
    logic          cls_err;
    logic [2:0]    unused_hits;

    logic [DW-1:0] br_addr_q, br_addr_d, br_wdata_q, br_wdata_d;
    logic [3:0]    br_byteen_q, br_byteen_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          merr0_q, merr0_d, merr1_q, merr1_d;
    logic          err_q, err_d, busy_q, busy_d;
    logic          grant_id_q, grant_id_d, last_grant_q, last_grant_d;

    assign req_any = m0_req || m1_req;

    // On conflict, round-robin favours whoever did not own the last transaction.
    always_comb begin
        if (m0_req && m1_req) begin
            sel = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
            sel = m1_req;
        end
    end

    assign sel_addr   = sel ? m1_addr   : m0_addr;
    assign sel_byteen = sel ? m1_byteen : m0_byteen;
    assign sel_wdata  = sel ? m1_wdata  : m0_wdata;

    bridge_arbiter_addr_classifier u_classifier (
        .addr_i    (sel_addr),
        .byteen_i  (sel_byteen),
        .hit_dm_o  (unused_hits[0]),
        .hit_tc0_o (unused_hits[1]),
        .hit_tc1_o (unused_hits[2]),
        .err_o     (cls_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = ACC;
            ACC:     state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        br_addr_d    = br_addr_q;
        br_wdata_d   = br_wdata_q;
        br_byteen_d  = 4'b0000;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        merr0_d      = 1'b0;
        merr1_d      = 1'b0;
        err_d        = err_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    br_addr_d   = sel_addr;
                    br_wdata_d  = sel_wdata;
                    // A faulty access is presented with no byte enables so no device sees it.
                    br_byteen_d = cls_err ? 4'b0000 : sel_byteen;
                    err_d       = cls_err;
                    grant_id_d  = sel;
                end
            end
            ACC: begin
                if (grant_id_q) begin
                    rdata1_d = err_q ? '0 : br_rdata;
                    ack1_d   = 1'b1;
                    merr1_d  = err_q;
                end else begin
                    rdata0_d = err_q ? '0 : br_rdata;
                    ack0_d   = 1'b1;
                    merr0_d  = err_q;
                end
            end
            RSP:     last_grant_d = grant_id_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_addr_q    <= '0;
            br_wdata_q   <= '0;
            br_byteen_q  <= 4'b0000;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            merr0_q      <= 1'b0;
            merr1_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            br_addr_q    <= br_addr_d;
            br_wdata_q   <= br_wdata_d;
            br_byteen_q  <= br_byteen_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            merr0_q      <= merr0_d;
            merr1_q      <= merr1_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign br_addr   = br_addr_q;
    assign br_wdata  = br_wdata_q;
    assign br_byteen = br_byteen_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_err    = merr0_q;
    assign m1_err    = merr1_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule
